// File: rtl/switch_pkg.sv
// Shared types for the switch output port: FSM state enum, byte width and
// the {eop, data} FIFO entry layout.
package switch_pkg;

    localparam int PORT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } port_state_e;

    typedef struct packed {
        logic              eop;
        logic [PORT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, occupancy count
// and full/empty flags. Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;
    assign full    = (r_count == DEPTH_C);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers and count, so clearing the data would only cost logic.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/switch_output_port.sv
// Egress side of one switch output port: buffers fabric bytes and streams one
// complete packet at a time onto port when the consumer asserts read.
module switch_output_port
    import switch_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = PORT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_full,
    output logic              overflow,
    input  logic              read,
    output logic              ready,
    output logic [DATA_W-1:0] port
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    port_state_e       r_state;
    port_state_e       w_state_nxt;
    fifo_entry_t       w_wr_entry;
    fifo_entry_t       w_rd_entry;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     r_pkt_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic              w_inc;
    logic              w_dec;
    logic              r_ready;
    logic              r_last;
    logic              r_overflow;
    logic [DATA_W-1:0] r_port;
    logic [DATA_W-1:0] w_port_nxt;
    logic              w_ready_nxt;
    logic              w_last_nxt;

    assign in_full    = (w_count == DEPTH_C);
    assign w_push     = in_valid & ~w_full;
    assign w_wr_entry = {in_eop, in_data};
    assign w_start    = (r_state == IDLE) & read & r_ready & ~w_empty;
    assign w_inc      = w_push & in_eop;
    assign w_dec      = w_pop & w_rd_entry.eop;

    assign ready    = r_ready;
    assign port     = r_port;
    assign overflow = r_overflow;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_wr_entry),
        .rd_data (w_rd_entry),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SEND;
            SEND:    if (r_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_last marks that the byte now on port is the eop; the next edge ends SEND.
    always_comb begin
        w_pop       = 1'b0;
        w_port_nxt  = '0;
        w_last_nxt  = 1'b0;
        w_ready_nxt = (r_pkt_count != '0);
        case (r_state)
            IDLE: if (w_start) begin
                w_pop       = 1'b1;
                w_port_nxt  = w_rd_entry.data;
                w_last_nxt  = w_rd_entry.eop;
                w_ready_nxt = 1'b0;
            end
            SEND: if (!r_last) begin
                w_pop       = 1'b1;
                w_port_nxt  = w_rd_entry.data;
                w_last_nxt  = w_rd_entry.eop;
                w_ready_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_port  <= '0;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_port  <= w_port_nxt;
            r_ready <= w_ready_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
            if (in_valid && in_full) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_output_port.sv
// Self-checking bench for switch_output_port: directed tables and sequences
// plus a randomized stream compared against a queue-based packet model.
module tb_switch_output_port;

    localparam int DEPTH = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_eop;
    logic       in_full;
    logic       overflow;
    logic       read;
    logic       ready;
    logic [7:0] port;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    switch_output_port #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_eop   (in_eop),
        .in_full  (in_full),
        .overflow (overflow),
        .read     (read),
        .ready    (ready),
        .port     (port)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of {eop,data}; stored packets are
    // the eop markers in it; a send pops a whole packet, one byte per edge.
    logic [8:0] m_q[$];
    bit         m_ready;
    bit         m_ovf;
    bit         m_send;
    logic [7:0] m_port;
    int         m_left;

    function automatic int m_packets();
        int n = 0;
        foreach (m_q[i]) if (m_q[i][8]) n++;
        return n;
    endfunction

    function automatic int m_first_len();
        for (int i = 0; i < m_q.size(); i++) if (m_q[i][8]) return i + 1;
        return m_q.size();
    endfunction

    task automatic model_step();
        int         pkts;
        bit         was_full;
        logic [8:0] x;
        if (reset) begin
            m_q.delete();
            m_ready = 0; m_ovf = 0; m_send = 0; m_port = '0; m_left = 0;
            return;
        end
        pkts     = m_packets();
        was_full = (m_q.size() == DEPTH);
        if (in_valid && was_full) m_ovf = 1;
        if (!m_send) begin
            if (read && m_ready) begin
                m_left  = m_first_len() - 1;
                x       = m_q.pop_front();
                m_port  = x[7:0];
                m_send  = 1;
                m_ready = 0;
            end else begin
                m_port  = '0;
                m_ready = (pkts != 0);
            end
        end else if (m_left == 0) begin
            m_send  = 0;
            m_port  = '0;
            m_ready = (pkts != 0);
        end else begin
            x      = m_q.pop_front();
            m_port = x[7:0];
            m_left--;
        end
        if (in_valid && !was_full) m_q.push_back({in_eop, in_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_port"},     port,     m_port);
        check({name, "_ready"},    ready,    m_ready);
        check({name, "_in_full"},  in_full,  (m_q.size() == DEPTH));
        check({name, "_overflow"}, overflow, m_ovf);
    endtask

    task automatic set_idle();
        in_valid = 0; in_eop = 0; in_data = '0; read = 0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic e);
        in_valid = 1; in_data = d; in_eop = e;
        tick();
        in_valid = 0; in_eop = 0;
    endtask

    task automatic pulse_read();
        read = 1;
        tick();
        read = 0;
    endtask

    typedef struct {
        logic       wv;
        logic       we;
        logic [7:0] wd;
        logic       rd;
        logic       exp_ready;
        logic [7:0] exp_port;
    } vec_t;

    vec_t       vt[9];
    logic [7:0] sb[$];
    int         written;
    bit         saw_full;

    task automatic observe();
        if (port != 8'h00) begin
            if (sb.size() == 0) check("extra_byte", port, 8'h00);
            else                check("order", port, sb.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00};
        vt[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00};
        vt[2] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00};
        vt[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11};
        vt[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22};
        vt[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33};
        vt[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

        // Reset state
        set_idle();
        reset = 1;
        tick();
        tick();
        check("rst_port", port, 8'h00);
        check("rst_ready", ready, 0);
        check("rst_in_full", in_full, 0);
        check("rst_overflow", overflow, 0);
        reset = 0;
        tick();

        // Single packet
        for (int i = 0; i < 9; i++) begin
            in_valid = vt[i].wv; in_eop = vt[i].we; in_data = vt[i].wd; read = vt[i].rd;
            tick();
            check($sformatf("single_ready[%0d]", i), ready, vt[i].exp_ready);
            check($sformatf("single_port[%0d]", i), port, vt[i].exp_port);
        end
        set_idle();

        // Partial packet never raises ready
        for (int i = 0; i < 4; i++) write_byte(8'h41 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("partial_ready", ready, 0);
        end
        write_byte(8'h45, 1'b1);
        check("partial_eop_edge_ready", ready, 0);
        tick();
        check("partial_ready_next", ready, 1);
        pulse_read();
        for (int i = 0; i < 5; i++) begin
            check("partial_port", port, 8'h41 + 8'(i));
            tick();
        end
        check("partial_port_end", port, 8'h00);
        check("partial_ready_end", ready, 0);

        // Back-to-back packets with read held high
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b1);
        write_byte(8'hB1, 1'b1);
        tick();
        check("b2b_ready", ready, 1);
        check("b2b_pkt2", dut.r_pkt_count, 2);
        read = 1;
        tick();
        check("b2b_a1", port, 8'hA1);
        check("b2b_a1_ready", ready, 0);
        tick();
        check("b2b_a2", port, 8'hA2);
        check("b2b_pkt1", dut.r_pkt_count, 1);
        tick();
        check("b2b_gap_port", port, 8'h00);
        check("b2b_gap_ready", ready, 1);
        tick();
        check("b2b_b1", port, 8'hB1);
        check("b2b_b1_ready", ready, 0);
        check("b2b_pkt0", dut.r_pkt_count, 0);
        tick();
        check("b2b_end_port", port, 8'h00);
        check("b2b_end_ready", ready, 0);
        read = 0;

        // Fill to capacity, overflow, then drain
        for (int i = 0; i < DEPTH; i++) write_byte(8'h80 + 8'(i), (i == DEPTH - 1));
        check("full_in_full", in_full, 1);
        check("full_no_ovf_yet", overflow, 0);
        write_byte(8'hEE, 1'b0);
        check("full_overflow", overflow, 1);
        check("full_still_full", in_full, 1);
        check("full_ready", ready, 1);
        pulse_read();
        check("full_first_byte", port, 8'h80);
        check("full_cleared_after_pop", in_full, 0);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            check("full_drain", port, 8'h80 + 8'(i));
        end
        tick();
        check("full_drain_end", port, 8'h00);
        check("full_ovf_sticky", overflow, 1);
        reset = 1;
        tick();
        check("ovf_cleared_by_reset", overflow, 0);
        reset = 0;
        tick();

        // Randomized stream: 200 packets of 5 bytes, read held high
        written  = 0;
        saw_full = 0;
        read     = 1;
        for (int cyc = 0; cyc < 8000 && written < 1000; cyc++) begin
            in_valid = 0; in_eop = 0;
            if (!in_full && $urandom_range(0, 1) == 1) begin
                in_valid = 1;
                in_data  = 8'($urandom_range(1, 255));
                in_eop   = (written % 5 == 4);
                sb.push_back(in_data);
                written++;
            end
            tick();
            check_model("rnd");
            observe();
            if (in_full) saw_full = 1;
        end
        in_valid = 0; in_eop = 0;
        check("rnd_all_written", written, 1000);
        for (int i = 0; i < 600 && sb.size() != 0; i++) begin
            tick();
            check_model("rnd_drain");
            observe();
        end
        check("rnd_sb_empty", sb.size(), 0);
        check("rnd_never_full", saw_full, 0);
        tick();
        tick();
        check("rnd_fifo_empty", dut.w_empty, 1);
        check("rnd_idle_port", port, 8'h00);
        read = 0;

        // Reset in the middle of a send
        for (int i = 0; i < 6; i++) write_byte(8'h61 + 8'(i), (i == 5));
        tick();
        check("mid_ready", ready, 1);
        pulse_read();
        check("mid_b0", port, 8'h61);
        tick();
        check("mid_b1", port, 8'h62);
        tick();
        check("mid_b2", port, 8'h63);
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_port", port, 8'h00);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_in_full", in_full, 0);
        check("mid_rst_pkt", dut.r_pkt_count, 0);
        check("mid_rst_empty", dut.w_empty, 1);
        tick();
        check("mid_after_ready", ready, 0);
        write_byte(8'h71, 1'b0);
        write_byte(8'h72, 1'b0);
        write_byte(8'h73, 1'b1);
        tick();
        check("mid_new_ready", ready, 1);
        pulse_read();
        for (int i = 0; i < 3; i++) begin
            check("mid_new_port", port, 8'h71 + 8'(i));
            check_model("mid_new");
            tick();
        end
        check("mid_new_end", port, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_output_port.md
# switch_output_port

Egress side of one switch output port. It accepts bytes from the switch fabric and buffers them in a byte FIFO. It raises `ready` when at least one complete packet is stored, and streams that packet onto `port` one byte per clock after the external consumer asserts `read`. It is the DUT-side counterpart of the port interface, which drives `read` and samples `port`/`ready`.

## Interface
- `DEPTH`, 64: FIFO capacity in bytes; power of two, at least 4.
- `DATA_W`, 8: byte width; fixed at 8 for the switch.
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  8: byte from the fabric.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_eop`  in  1: qualifies `in_valid`; the byte is the last of its packet.
- `in_full`  out  1: FIFO full; the fabric must not assert `in_valid`.
- `overflow`  out  1: sticky; set when a write is attempted while full.
- `read`  in  1: consumer request; acted on only when `ready` = 1.
- `ready`  out  1: registered; a complete packet is available and the port is idle.
- `port`  out  8: registered egress byte; 0 when not sending.

## Operation
- FIFO entries are 9 bits: {eop, data}.
- Write rule: a write occurs when `in_valid` & !`in_full`.
  - `in_valid` & `in_full` drops the byte and sets `overflow`.
  - `overflow` clears only on `reset`.
- `pkt_count` counts complete packets stored. Its width is $clog2(DEPTH)+1.
  - Increments on an accepted write with `in_eop` = 1.
  - Decrements when the eop byte is popped.
  - Increment and decrement in the same cycle leave it unchanged.
- A partial packet (no eop yet written) never raises `ready`.
- FSM states: IDLE, SEND.
  - IDLE: `port` = 0; `ready` = (`pkt_count` != 0).
  - IDLE → SEND when `read` & `ready` are sampled high. On that edge, pop the first byte to `port` and set `ready` to 0.
  - SEND: pop one byte per cycle to `port`. `read` is ignored; the packet always completes.
  - SEND → IDLE on the edge after the eop byte was presented. On that edge, `port` = 0 and `ready` recomputes from `pkt_count`.
- `read` while `ready` = 0 is ignored; nothing pops.
- Simultaneous push and pop: byte count unchanged; both operations take effect.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap naturally. `in_full` = (count == DEPTH).
- Packets are emitted strictly in arrival order with no reordering.
- Reset, including mid-packet:
  - State goes to IDLE, the FIFO empties, and both counters go to 0.
  - `port` = 0, `ready` = 0, `in_full` = 0, `overflow` = 0.
  - A partially sent packet is discarded.

## Timing
- `in_full` is combinational from count. A write accepted at edge E is counted at E.
- A packet with eop written at edge E: `pkt_count` updates at E, and `ready` goes to 1 at E+1.
- `read` sampled high at edge T with `ready` = 1:
  - Byte 0 appears on `port` after T.
  - Byte k appears after edge T+k.
  - For a packet of L bytes, the last byte is valid in the cycle after T+L−1.
  - `port` returns to 0 after T+L.
- `ready` is low from T through T+L−1. After T+L, `ready` = 1 if another complete packet is stored. The minimum gap between packets is one idle cycle.
- A 1-byte packet (eop on the first byte) is legal: L = 1.

## Structure
- `switch_pkg` holds:
  - the `port_state_e` enum {IDLE, SEND};
  - `PORT_W` = 8;
  - the FIFO entry struct {eop, data}.
- One sub-module, `sync_fifo`, parameterized by width and depth, with `push`, `pop`, `full`, `empty` and `count`.
- The FSM, `pkt_count`, `overflow` and the `port`/`ready` output registers live in `switch_output_port`.

## Test plan
- **Single packet:** write 0x11, 0x22, 0x33 (eop on 0x33), then pulse `read`. Expect `ready` high one cycle after the eop write and low after `read`; `port` = 0x11, 0x22, 0x33 on three consecutive cycles, then 0x00.
- **Partial packet:** write 4 bytes without eop. Expect `ready` to stay 0 for 20 cycles; then write the eop byte and expect `ready` = 1 on the next cycle.
- **Back-to-back:** store packets A (2 bytes) and B (1 byte), then hold `read` high. Expect the A bytes, then one idle cycle with `port` = 0 and `ready` = 1, then the B byte. `pkt_count` goes 2→1→0.
- **Full/overflow:** write 64 bytes with eop on the last. Expect `in_full` = 1; a 65th write is dropped and `overflow` = 1. Read out and expect all 64 bytes intact, `in_full` = 0 after the first pop, and `overflow` still 1.
- **Simultaneous push/pop with wrap:** stream 200 packets of 5 bytes while reading continuously. Expect no loss, correct order, pointers wrapping, and `in_full` never asserted.
- **Reset mid-packet:** assert `reset` at byte 2 of a 6-byte send. Expect `port` = 0, `ready` = 0, `in_full` = 0 on the next cycle and the FIFO empty; a new packet afterwards sends correctly.
